maxpool_ctrl: RTL and testbench

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

---
 rtl/maxpool_ctrl.sv | 159 +++++++++++++++
 tb/tb_maxpool_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl.sv
`timescale 1ns/1ps
// maxpool_ctrl: streaming PxP / stride-P signed max-pool over a W x H frame
// received in row-major order, with start/abort control and output backpressure.
module maxpool_ctrl #(
    parameter int N = 16,
    parameter int W = 4,
    parameter int H = 4,
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         master_rst,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int NW = W / P;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            done_q, done_d;

    logic            accept;
    logic            col_last, row_last;
    logic            win_first, win_last;
    logic [KW-1:0]   k;
    logic [NW*N-1:0] pmax_flat;
    logic [N-1:0]    cur_max, new_max;

    assign accept    = in_valid && in_ready && !abort;
    assign col_last  = (col_q == CW'(W - 1));
    assign row_last  = (row_q == RW'(H - 1));
    assign win_first = ((row_q % RW'(P)) == '0) && ((col_q % CW'(P)) == '0);
    assign win_last  = ((row_q % RW'(P)) == RW'(P - 1)) && ((col_q % CW'(P)) == CW'(P - 1));
    assign k         = KW'(col_q / CW'(P));
    assign cur_max   = pmax_flat[int'(k)*N +: N];
    assign new_max   = ($signed(in_data) > $signed(cur_max)) ? in_data : cur_max;

    // One running maximum per window column; a window row band reuses them.
    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_pmax
            logic [N-1:0] pmax_q, pmax_d;

            always_comb begin
                pmax_d = pmax_q;
                if (abort) begin
                    pmax_d = '0;
                end else if (accept && (k == KW'(gi))) begin
                    pmax_d = win_first ? in_data : new_max;
                end
            end

            always_ff @(posedge clk or posedge master_rst) begin
                if (master_rst) begin
                    pmax_q <= '0;
                end else begin
                    pmax_q <= pmax_d;
                end
            end

            assign pmax_flat[gi*N +: N] = pmax_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (accept && col_last && row_last) state_d = FLUSH;
                FLUSH:   if (!out_valid_q || out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
        busy      = (state_q == RUN) || (state_q == FLUSH);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        done      = done_q;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = !abort && (state_q == FLUSH) && (!out_valid_q || out_ready);
        if (abort) begin
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                col_d = '0;
                row_d = '0;
            end
            if (accept) begin
                col_d = col_last ? '0 : col_q + CW'(1);
                if (col_last) begin
                    row_d = row_last ? '0 : row_q + RW'(1);
                end
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            // A fresh result wins over the handshake that retires the old one.
            if (accept && win_last) begin
                out_valid_d = 1'b1;
                out_data_d  = new_max;
            end
        end
    end

    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
`timescale 1ns/1ps
// Bench for maxpool_ctrl: directed and random frames, expected window maxima
// pushed into a queue at each window-last accept and retired by a monitor.
module tb_maxpool_ctrl;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int P  = 2;
    localparam int NR = (W / P) * (H / P);

    logic         clk = 1'b0;
    logic         master_rst, start, abort, in_valid, out_ready;
    logic [N-1:0] in_data;
    logic         in_ready, out_valid, busy, done;
    logic [N-1:0] out_data;

    maxpool_ctrl #(.N(N), .W(W), .H(H), .P(P)) dut (
        .clk(clk), .master_rst(master_rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    int last_hs = -100;
    int d0 = 0;
    int r0 = 0;
    int pix_idx = 0;
    bit prev_done = 1'b0;
    bit rnd_ready = 1'b0;
    bit ready_fixed = 1'b1;
    bit gaps = 1'b0;
    logic [N-1:0] exp_q[$];
    logic signed [N-1:0] img[W*H];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: maximum of the PxP window at window coordinates (wr, wc).
    function automatic logic [N-1:0] win_max(input int wr, input int wc);
        logic signed [N-1:0] m;
        m = img[wr*P*W + wc*P];
        for (int dr = 0; dr < P; dr++)
            for (int dc = 0; dc < P; dc++)
                if (img[(wr*P + dr)*W + wc*P + dc] > m) m = img[(wr*P + dr)*W + wc*P + dc];
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Monitor: retire one expected result per output handshake, watch done.
    initial forever begin
        @(negedge clk);
        if (!master_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%0h required=none", out_data);
            end else begin
                chk("result", 32'(out_data), 32'(exp_q.pop_front()));
            end
            res_cnt++;
            last_hs = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_latency", 32'(cyc), 32'(last_hs + 1));
            chk("done_width", 32'(prev_done), 32'd0);
        end
        prev_done = done;
    end

    task automatic send(input logic [N-1:0] v);
        int t = 0;
        bit acc = 1'b0;
        int r, c;
        logic [N-1:0] e;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            img[pix_idx] = v;
            r = pix_idx / W;
            c = pix_idx % W;
            pix_idx++;
            if ((r % P == P - 1) && (c % P == P - 1)) begin
                e = win_max(r / P, c / P);
                exp_q.push_back(e);
                chk("latency_valid", 32'(out_valid), 32'd1);
                chk("latency_data", 32'(out_data), 32'(e));
            end
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pix_idx = 0;
        d0 = done_cnt;
        r0 = res_cnt;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_frame();
        int t = 0;
        while (busy && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_end_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
        chk("frame_result_count", 32'(res_cnt - r0), 32'(NR));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] sgn[8];
        master_rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        master_rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset");

        // Ascending frame, with a stray start pulse in RUN that must be ignored.
        start_frame();
        for (int i = 1; i <= 16; i++) begin
            send(N'(i));
            if (i == 3) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("start_in_run_busy", 32'(busy), 32'd1);
            end
        end
        finish_frame();

        // Signed extremes in the top window band.
        sgn[0] = 16'hFFFB; sgn[1] = 16'hFFFD; sgn[2] = 16'h8000; sgn[3] = 16'h8000;
        sgn[4] = 16'hFFF9; sgn[5] = 16'hFFFF; sgn[6] = 16'h7FFF; sgn[7] = 16'h8000;
        start_frame();
        for (int i = 0; i < 8; i++) send(sgn[i]);
        for (int i = 8; i < 16; i++) send(N'($urandom));
        finish_frame();

        // Backpressure: stall after the first result, then release.
        ready_fixed = 1'b0;
        @(posedge clk);
        #1;
        start_frame();
        for (int i = 1; i <= 6; i++) send(N'(i));
        in_valid = 1'b1;
        in_data  = N'(7);
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", 32'(out_data), 32'd6);
        end
        @(posedge clk);
        #1;
        ready_fixed = 1'b1;
        for (int i = 7; i <= 16; i++) send(N'(i));
        finish_frame();

        // Reset in the middle of a frame.
        start_frame();
        for (int i = 1; i <= 7; i++) send(N'(i));
        master_rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        master_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_stays_idle", 32'(busy), 32'd0);
        chk("mid_reset_queue_empty", 32'(exp_q.size()), 32'd0);
        start_frame();
        for (int i = 1; i <= 16; i++) send(N'(i));
        finish_frame();

        // Abort coinciding with the fourth pixel.
        start_frame();
        for (int i = 1; i <= 3; i++) send(N'(i));
        in_valid = 1'b1;
        in_data  = N'(4);
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_result", 32'(res_cnt - r0), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);

        // Two back-to-back random frames with random gaps on both sides.
        rnd_ready = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 2; f++) begin
            start_frame();
            for (int i = 0; i < 16; i++) send(N'($urandom));
            finish_frame();
        end
        rnd_ready = 1'b0;
        gaps = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
